// File: rtl/pcpi_issue_arbiter.sv
// Round-robin issue arbiter sharing one PCPI coprocessor between two requesters.
// Latches the winning op, runs the PCPI handshake with no-wait timeout, returns result.
module pcpi_issue_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_insn,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic        rsp_timeout,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        busy,
  output logic        err_spurious
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             gnt_idx;
  logic             gnt_any;
  logic             cnt_last;
  logic             own_ack;

  // Both requesting: the one that did not win last time goes next.
  always_comb begin
    gnt_idx = 1'b0;
    unique case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign gnt_any  = (state == S_IDLE) && (|req_valid);
  assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));
  assign own_ack  = owner ? rsp_ready[1] : rsp_ready[0];

  always_comb begin
    req_ready = 2'b00;
    if (gnt_any) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == S_RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

  assign pcpi_valid = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      pcpi_insn   <= '0;
      pcpi_rs1    <= '0;
      pcpi_rs2    <= '0;
      rsp_rd      <= '0;
      rsp_wr      <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            pcpi_insn  <= gnt_idx ? req_insn[63:32] : req_insn[31:0];
            pcpi_rs1   <= gnt_idx ? req_rs1[63:32]  : req_rs1[31:0];
            pcpi_rs2   <= gnt_idx ? req_rs2[63:32]  : req_rs2[31:0];
            owner      <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A ready in the timeout cycle still delivers the real result.
          if (pcpi_ready) begin
            rsp_rd      <= pcpi_rd;
            rsp_wr      <= pcpi_wr;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (pcpi_wait) begin
            cnt <= '0;
          end else if (cnt_last) begin
            rsp_rd      <= '0;
            rsp_wr      <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (own_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_spurious <= 1'b0;
    end else if (pcpi_ready && (state != S_ISSUE)) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcpi_issue_arbiter.sv
// Directed bench for pcpi_issue_arbiter.
// Bench plays the coprocessor and both requesters.
module tb_pcpi_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_insn = '0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_rd;
  logic        rsp_wr;
  logic        rsp_timeout;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_ready = 1'b0;
  logic        busy;
  logic        err_spurious;

  int total = 0;
  int bad = 0;
  int vc;

  pcpi_issue_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_insn(req_insn),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_wr(rsp_wr),
    .rsp_timeout(rsp_timeout),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Act as coprocessor: nw wait cycles, ni idle cycles, then ready
  // (if give). Returns number of cycles pcpi_valid was high.
  task automatic serve(input int nw, input int ni, input bit give,
                       input logic [31:0] rd, input logic wr,
                       output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (!pcpi_valid) break;
      cyc++;
      pcpi_wait = (cyc <= nw);
      if (give && cyc == nw + ni + 1) begin
        pcpi_ready = 1'b1;
        pcpi_rd = rd;
        pcpi_wr = wr;
      end
      step();
      pcpi_ready = 1'b0;
      pcpi_wait = 1'b0;
      pcpi_rd = '0;
      pcpi_wr = 1'b0;
    end
    if (pcpi_valid) check("serve_bound", 64'(pcpi_valid), 64'd0);
  endtask

  task automatic accept(input string tag, input logic [1:0] exp);
    rsp_ready = exp;
    step();
    rsp_ready = 2'b00;
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(pcpi_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_rdy", 64'(req_ready), 64'd0);
    check("rst_err", 64'(err_spurious), 64'd0);
    step();
    rst = 1'b0;
    step();

    // single op
    req_insn = {32'h0, 32'h0200_000B};
    req_rs1 = {32'h0, 32'd5};
    req_rs2 = {32'h0, 32'd7};
    req_valid = 2'b01;
    #1;
    check("t1_rdy", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    check("t1_insn", 64'(pcpi_insn), 64'h0200_000B);
    check("t1_rs1", 64'(pcpi_rs1), 64'd5);
    check("t1_rs2", 64'(pcpi_rs2), 64'd7);
    serve(3, 0, 1'b1, 32'd35, 1'b1, vc);
    check("t1_vcyc", 64'(vc), 64'd4);
    check("t1_rspv", 64'(rsp_valid), 64'd1);
    check("t1_rd", 64'(rsp_rd), 64'd35);
    check("t1_wr", 64'(rsp_wr), 64'd1);
    check("t1_to", 64'(rsp_timeout), 64'd0);
    accept("t1", 2'b01);

    // contention: grant order 0,1,0
    do_reset();
    req_insn = {32'hB1B1_0001, 32'hA0A0_0000};
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      automatic logic [1:0] eg = (k == 1) ? 2'b10 : 2'b01;
      automatic logic [31:0] ei = (k == 1) ? 32'hB1B1_0001 : 32'hA0A0_0000;
      #1;
      check("ct_rdy", 64'(req_ready), 64'(eg));
      step();
      check("ct_insn", 64'(pcpi_insn), 64'(ei));
      check("ct_rdy_busy", 64'(req_ready), 64'd0);
      serve(0, 0, 1'b1, 32'(k), 1'b0, vc);
      check("ct_owner", 64'(rsp_valid), 64'(eg));
      rsp_ready = eg;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    step();

    // timeout
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    serve(0, 0, 1'b0, 32'h0, 1'b0, vc);
    check("to_vcyc", 64'(vc), 64'd16);
    check("to_flag", 64'(rsp_timeout), 64'd1);
    check("to_rd", 64'(rsp_rd), 64'd0);
    check("to_wr", 64'(rsp_wr), 64'd0);
    accept("to", 2'b10 ^ 2'b11);

    // wait extends op, ready on 16th no-wait cycle
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    serve(40, 15, 1'b1, 32'h1234, 1'b1, vc);
    check("wt_vcyc", 64'(vc), 64'd56);
    check("wt_to", 64'(rsp_timeout), 64'd0);
    check("wt_rd", 64'(rsp_rd), 64'h1234);
    check("wt_rspv", 64'(rsp_valid), 64'd2);
    accept("wt", 2'b10);

    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    serve(0, 15, 1'b1, 32'h55, 1'b0, vc);
    check("edge_vcyc", 64'(vc), 64'd16);
    check("edge_to", 64'(rsp_timeout), 64'd0);
    check("edge_rd", 64'(rsp_rd), 64'h55);
    accept("edge", 2'b01);

    // backpressure + spurious ready
    req_valid = 2'b01;
    step();
    serve(0, 0, 1'b1, 32'hDEAD, 1'b1, vc);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      rsp_ready = (i == 4) ? 2'b10 : 2'b00;
      #1;
      check("bp_rspv", 64'(rsp_valid), 64'd1);
      check("bp_rd", 64'(rsp_rd), 64'hDEAD);
      check("bp_nogrant", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 2'b00;
    check("bp_err0", 64'(err_spurious), 64'd0);
    pcpi_ready = 1'b1;
    pcpi_rd = 32'h7777;
    step();
    pcpi_ready = 1'b0;
    pcpi_rd = '0;
    check("sp_err", 64'(err_spurious), 64'd1);
    check("sp_rd", 64'(rsp_rd), 64'hDEAD);
    req_valid = 2'b00;
    accept("sp", 2'b01);
    step();
    check("sp_sticky", 64'(err_spurious), 64'd1);

    // async reset mid-ISSUE
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    check("ar_pre", 64'(pcpi_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(pcpi_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_rsp", 64'(rsp_valid), 64'd0);
    check("ar_err", 64'(err_spurious), 64'd0);
    step();
    rst = 1'b0;
    step();
    req_valid = 2'b11;
    #1;
    check("ar_first", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    check("ar_issue", 64'(pcpi_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcpi_issue_arbiter.md
Name: pcpi_issue_arbiter

Overview:
- Shares one PCPI coprocessor (the fused matrix-multiply unit) between two instruction requesters, e.g. the nibble-loader front end and a self-test sequencer.
- Arbitrates round-robin and latches the winning instruction and operands.
- Drives the PCPI valid/ready handshake, enforces the PCPI no-wait timeout, and returns the result to the owning requester with backpressure.

Parameters:
- TIMEOUT, 16: cycles pcpi_valid may stay high with pcpi_wait and pcpi_ready both low before the op is aborted as illegal.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  2  per-requester issue request; held until accepted
- req_insn  input  64  {insn1, insn0}, 32 bits each
- req_rs1  input  64  {rs1_1, rs1_0}
- req_rs2  input  64  {rs2_1, rs2_0}
- req_ready  output  2  one-hot accept, combinational, at most one bit set
- rsp_valid  output  2  one-hot result valid to the owner
- rsp_ready  input  2  per-requester result accept
- rsp_rd  output  32  captured pcpi_rd
- rsp_wr  output  1  captured pcpi_wr
- rsp_timeout  output  1  op aborted by timeout
- pcpi_valid  output  1  PCPI request
- pcpi_insn  output  32  latched instruction
- pcpi_rs1  output  32  latched rs1
- pcpi_rs2  output  32  latched rs2
- pcpi_wr  input  1  coprocessor writes rd
- pcpi_rd  input  32  coprocessor result
- pcpi_wait  input  1  coprocessor busy, suppresses timeout
- pcpi_ready  input  1  coprocessor done, single-cycle pulse
- busy  output  1  state != IDLE
- err_spurious  output  1  sticky: pcpi_ready seen outside ISSUE

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, latched regs 0, counter 0, owner=0, last_grant=1 so requester 0 wins first.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant requester g: if only one req_valid is set, that one; if both, the one != last_grant.
  - req_ready[g]=1 combinationally in the same cycle.
  - At the edge: latch insn/rs1/rs2[g], owner=g, last_grant=g, counter=0, go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - pcpi_valid=1 (decoded from the state register); pcpi_insn/rs1/rs2 stable from the latches.
  - pcpi_ready=1: capture rd/wr, rsp_timeout=0, go to RESP. pcpi_valid is low from the next cycle.
  - Else if pcpi_wait=1: counter resets to 0.
  - Else: counter increments. When counter==TIMEOUT-1 and pcpi_ready=0, capture rd=0, wr=0, rsp_timeout=1, go to RESP. pcpi_valid is high for exactly TIMEOUT cycles.
  - pcpi_ready and timeout in the same cycle: ready wins.
- RESP:
  - rsp_valid[owner]=1; rsp_rd/wr/timeout held stable.
  - On rsp_ready[owner]: go to IDLE. rsp_ready on the non-owner bit is ignored.
- Latency: accept at edge T; pcpi_valid high in cycle T+1; response cycle follows the pcpi_ready cycle. Minimum turnaround is one IDLE cycle between ops.
- rsp_rd/wr/timeout keep their last values outside RESP; they are only meaningful while rsp_valid is high.
- err_spurious sets on pcpi_ready in IDLE or RESP and clears only on rst. A spurious ready is otherwise ignored.
- A request withdrawn before acceptance is legal. After acceptance, the requester's inputs are don't-care.

Test Plan:
- Single op: req_valid=01, insn0=0x0200_000B, rs1=5, rs2=7; coprocessor pulses wait 3 cycles then ready with rd=35, wr=1 -> req_ready=01 same cycle; pcpi_valid high 4 cycles; rsp_valid=01, rsp_rd=35, rsp_wr=1, rsp_timeout=0; IDLE after rsp_ready=01.
- Contention: after reset, req_valid=11 held for 3 ops -> grant order 0,1,0; insn latched matches the granted requester each time.
- Timeout: TIMEOUT=16, no wait/ready -> pcpi_valid high exactly 16 cycles; rsp_timeout=1, rsp_rd=0, rsp_wr=0.
- Wait extends op: wait high 40 cycles, then low 15 cycles, then ready -> no timeout; result delivered. Ready arriving on the 16th no-wait cycle also yields rsp_timeout=0.
- Backpressure and spurious ready: hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rd stable, no new grant. Pulse pcpi_ready during RESP -> err_spurious=1 and stays set.
- Async reset asserted mid-ISSUE, between edges -> pcpi_valid, busy, rsp_valid drop immediately. After release, a req_valid=11 grants requester 0 first.
